// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command/response bytes,
// LED mask bit positions and the odd-parity helper used on the wire.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    STOP,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;

  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;

  // PS/2 parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-level request/status handshake between a PS/2 command source and ps2_host_tx.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_done, tx_error, rx_inhibit
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_done, tx_error, rx_inhibit
  );

endinterface

// File: rtl/ps2_line_sync.sv
// 2-FF synchronisers for the raw PS/2 clock/data pads plus a registered falling-edge
// strobe on the clock (pad-to-strobe latency 3 clk). Shared with the PS/2 receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic clk_fe
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: synchronisers reset to 1 (idle bus) so leaving reset never fakes a falling edge.
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
      clk_fe   <= 1'b0;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_i};
      data_ff  <= {data_ff[0], ps2_data_i};
      clk_prev <= clk_ff[1];
      clk_fe   <= clk_prev & ~clk_ff[1];
    end
  end

  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data + odd parity + stop,
// device ACK check. Optional frame watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 14_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  ps2_host_tx_if.slave  tx_if
);

  localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int WD_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
  // One counter times the inhibit interval and then, when enabled, the frame watchdog.
  localparam int CNT_W   = $clog2(((WD_CYC > INH_CYC) ? WD_CYC : INH_CYC) + 1);

  logic clk_s;
  logic data_s;
  logic clk_fe;

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fe     (clk_fe)
  );

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bitcnt;
  logic [7:0]       shreg;
  logic             parity;
  logic             ack_err;
  logic             busy;
  logic             done;
  logic             error;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
      ack_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_if.tx_start) begin
            shreg      <= tx_if.tx_data;
            parity     <= odd_parity(tx_if.tx_data);
            ps2_clk_oe <= 1'b1;
            busy       <= 1'b1;
            error      <= 1'b0;
            cnt        <= CNT_W'(INH_CYC);
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == '0) begin
            ps2_data_oe <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            state       <= RTS;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            cnt         <= CNT_W'(WD_CYC);
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RTS: begin
          if (clk_fe) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= shreg >> 1;
            bitcnt      <= 4'd1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (clk_fe) begin
            if (bitcnt == 4'd8) begin
              ps2_data_oe <= ~parity;
              state       <= STOP;
            end else begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= shreg >> 1;
              bitcnt      <= bitcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (clk_fe) begin
            ps2_data_oe <= 1'b0;
            state       <= ACK;
          end
        end
        ACK: begin
          if (clk_fe) begin
            ack_err <= data_s;
            state   <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done   <= 1'b1;
            busy   <= 1'b0;
            error  <= ack_err;
            bitcnt <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Watchdog overrides whatever the frame logic decided this cycle.
      if (state != IDLE && state != INHIBIT) begin
        if (cnt == '0) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          error       <= 1'b1;
          bitcnt      <= '0;
          state       <= IDLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
`endif
    end
  end

  assign tx_if.tx_busy    = busy;
  assign tx_if.tx_done    = done;
  assign tx_if.tx_error   = error;
  assign tx_if.rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames at 40 us and returns ACK/NACK.
module tb_ps2_host_tx;

  localparam int HALF = 280;  // 20 us at 14 MHz

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic ps2_clk_i;
  logic ps2_data_i;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;

  logic [9:0] seen;
  int         hold;
  int         d0;

  ps2_host_tx_if tx_if ();

  // Open-drain pads: either side may pull low.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_if       (tx_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_if.tx_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(posedge clk); #1;
    tx_if.tx_data  = d;
    tx_if.tx_start = 1'b1;
    @(posedge clk); #1;
    tx_if.tx_start = 1'b0;
  endtask

  // Device model: measures the inhibit, then generates n_edges clock pulses, sampling the
  // host's data on each rising edge; edge 11 carries the ACK when ack_low is set.
  task automatic device_frame(input int n_edges, input bit ack_low, input bit start_at_done,
                              output logic [9:0] bits, output int held);
    int budget;
    bits = '0;
    held = 0;
    budget = 0;
    while (ps2_clk_oe !== 1'b1 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (ps2_clk_oe !== 1'b1) begin
      check("inhibit_seen", {31'd0, ps2_clk_oe}, 32'd1);
      return;
    end
    while (ps2_clk_oe === 1'b1 && held < 10000) begin
      @(posedge clk); #1;
      held++;
    end
    check("start_bit", {31'd0, ps2_data_i}, 32'd0);
    for (int i = 0; i < n_edges; i++) begin
      if (i == 10 && ack_low) dev_data = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 dev_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2_data_i;
    end
    if (n_edges == 11) begin
      repeat (20) @(posedge clk);
      #1 dev_data = 1'b1;
      if (start_at_done) begin
        // Data reaches the synchroniser output after two edges; done is produced on the third.
        @(posedge clk);
        @(posedge clk); #1;
        tx_if.tx_data  = 8'hAA;
        tx_if.tx_start = 1'b1;
        @(posedge clk); #1;
        tx_if.tx_start = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int expect_cnt);
    int budget;
    budget = 0;
    while (done_cnt < expect_cnt && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    check("done_count", done_cnt, expect_cnt);
  endtask

  initial begin
    tx_if.tx_data  = 8'h00;
    tx_if.tx_start = 1'b0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("rst_busy", {31'd0, tx_if.tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_if.tx_done}, 32'd0);
    check("rst_error", {31'd0, tx_if.tx_error}, 32'd0);
    check("rst_rx_inh", {31'd0, tx_if.rx_inhibit}, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // 0xED: data 1,0,1,1,0,1,1,1 LSB-first, parity 1, stop 1
    d0 = done_cnt;
    start_tx(8'hED);
    check("busy_after_start", {31'd0, tx_if.tx_busy}, 32'd1);
    check("rx_inh_after_start", {31'd0, tx_if.rx_inhibit}, 32'd1);
    device_frame(11, 1'b1, 1'b0, seen, hold);
    check("inhibit_len_ge_1680", {31'd0, hold >= 1680}, 32'd1);
    check("bits_ED", {22'd0, seen}, 32'h3ED);
    wait_done(d0 + 1);
    check("err_ED", {31'd0, tx_if.tx_error}, 32'd0);
    check("busy_ED", {31'd0, tx_if.tx_busy}, 32'd0);
    check("rx_inh_ED", {31'd0, tx_if.rx_inhibit}, 32'd0);
    check("lines_released_ED", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (20) @(posedge clk);
    #1 check("single_done_ED", done_cnt, d0 + 1);

    // 0x00 -> parity 1
    d0 = done_cnt;
    start_tx(8'h00);
    device_frame(11, 1'b1, 1'b0, seen, hold);
    check("bits_00", {22'd0, seen}, 32'h300);
    wait_done(d0 + 1);
    check("err_00", {31'd0, tx_if.tx_error}, 32'd0);

    // 0x01 -> parity 0
    d0 = done_cnt;
    start_tx(8'h01);
    device_frame(11, 1'b1, 1'b0, seen, hold);
    check("bits_01", {22'd0, seen}, 32'h201);
    wait_done(d0 + 1);
    check("err_01", {31'd0, tx_if.tx_error}, 32'd0);

    // No ACK from the device
    d0 = done_cnt;
    start_tx(8'hFF);
    device_frame(11, 1'b0, 1'b0, seen, hold);
    check("bits_FF", {22'd0, seen}, 32'h3FF);
    wait_done(d0 + 1);
    check("err_nack", {31'd0, tx_if.tx_error}, 32'd1);
    repeat (200) @(posedge clk);
    #1 check("err_nack_held", {31'd0, tx_if.tx_error}, 32'd1);

    // Next start clears the error; starts mid-frame and on the done edge are ignored
    d0 = done_cnt;
    start_tx(8'hF4);
    check("err_cleared", {31'd0, tx_if.tx_error}, 32'd0);
    fork
      device_frame(11, 1'b1, 1'b1, seen, hold);
      begin
        repeat (3000) @(posedge clk);
        #1;
        tx_if.tx_data  = 8'h55;
        tx_if.tx_start = 1'b1;
        @(posedge clk); #1;
        tx_if.tx_start = 1'b0;
      end
    join
    check("bits_F4", {22'd0, seen}, 32'h2F4);
    wait_done(d0 + 1);
    check("err_F4", {31'd0, tx_if.tx_error}, 32'd0);
    repeat (100) @(posedge clk);
    #1;
    check("start_at_done_ignored", {31'd0, tx_if.tx_busy}, 32'd0);
    check("no_extra_inhibit", {31'd0, ps2_clk_oe}, 32'd0);
    check("one_frame_F4", done_cnt, d0 + 1);

    // Reset while bit4 is on the wire
    d0 = done_cnt;
    start_tx(8'hED);
    device_frame(5, 1'b0, 1'b0, seen, hold);
    check("busy_mid_frame", {31'd0, tx_if.tx_busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("mid_rst_busy", {31'd0, tx_if.tx_busy}, 32'd0);
    reset = 1'b0;
    repeat (50) @(posedge clk);
    #1 check("mid_rst_no_done", done_cnt, d0);

    // Recovery frame 0x02 -> parity 0
    start_tx(8'h02);
    device_frame(11, 1'b1, 1'b0, seen, hold);
    check("bits_02", {22'd0, seen}, 32'h202);
    wait_done(d0 + 1);
    check("err_02", {31'd0, tx_if.tx_error}, 32'd0);

    // Silent device
    d0 = done_cnt;
    start_tx(8'hF4);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    begin
      int budget;
      budget = 0;
      while (done_cnt == d0 && budget < 220000) begin
        @(posedge clk); #1;
        budget++;
      end
      check("timeout_done", done_cnt, d0 + 1);
      check("timeout_err", {31'd0, tx_if.tx_error}, 32'd1);
      check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("timeout_busy", {31'd0, tx_if.tx_busy}, 32'd0);
    end
`else
    repeat (5000) @(posedge clk);
    #1;
    check("silent_busy", {31'd0, tx_if.tx_busy}, 32'd1);
    check("silent_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
    check("silent_no_done", done_cnt, d0);
`endif
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one byte to the keyboard, for example the LED command 0xED followed by an LED mask, or reset 0xFF.
- Sits beside the PS/2 receiver on the same open-drain ps2_clk/ps2_data pins.
- Performs clock inhibit, request-to-send, bit shifting on device clock edges, odd parity, stop bit and device ACK check.
- Drives the receiver's ignore window through rx_inhibit.

Parameters:
- CLK_HZ, 14000000, system clock frequency.
- INHIBIT_US, 120, how long ps2_clk is held low before request-to-send.
- TIMEOUT_MS, 15, abort limit for the whole frame (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk_i  in  1  raw pad level of PS/2 clock.
- ps2_data_i  in  1  raw pad level of PS/2 data.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release the line.
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release the line.
- tx_data  in  8  byte to send; sampled when tx_start is accepted.
- tx_start  in  1  single-cycle request.
- tx_busy  out  1  high from acceptance until the cycle done pulses.
- tx_done  out  1  one-cycle pulse at end of frame.
- tx_error  out  1  valid with tx_done: 1 = no ACK or timeout. Held until next accepted start.
- rx_inhibit  out  1  equals tx_busy; the receiver discards frames while it is high.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0, state=IDLE, bit counter=0.
- Reset mid-frame releases both lines on the next clk edge; no done pulse is produced.
- Input conditioning: ps2_clk_i and ps2_data_i pass through 2-FF synchronisers. A falling edge (fe) is prev=1, cur=0 on the synchronised clock, so latency from pad to fe is 3 clk.
- Constant INH_CYC = CLK_HZ/1_000_000*INHIBIT_US, giving 1680 at default values.
- IDLE:
  - tx_start=1 accepts the request: latch tx_data and compute parity = ~^tx_data (odd).
  - Set clk_oe=1, tx_busy=1, clear tx_error, load counter with INH_CYC, go to INHIBIT.
  - tx_start while busy is ignored and not queued.
- INHIBIT: counter decrements each cycle. At 0: data_oe=1 (start bit), clk_oe=0, go to RTS.
- RTS: wait for fe. On fe, drive bit0 with data_oe=~shreg[0], set bitcnt=1, go to DATA.
- DATA: on each fe, drive the next bit LSB-first. After bit7 is driven (bitcnt=8), the next fe drives parity, then go to STOP.
- STOP: on fe, release data (data_oe=0), go to ACK.
- ACK: on fe, sample synchronised data. 0 = ACK OK; 1 = error. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronised clk=1 and data=1 on the same cycle. Then tx_done=1 for one cycle, tx_busy=0, tx_error=ack error, go to IDLE.
- Frame edge count: 11 device falling edges after request-to-send (8 data, parity, stop, ack).
- Simultaneous tx_start and tx_done: the start is ignored because tx_busy is still 1 in that cycle.
- rx_inhibit drops in the same cycle as tx_busy.
- ps2_clk_oe and ps2_data_oe are registered outputs.

Optional Feature:
- Macro PS2_HOST_TX_TIMEOUT_EN.
- When defined:
  - A frame watchdog counter of CLK_HZ/1000*TIMEOUT_MS cycles starts when the INHIBIT state ends.
  - Expiry in any state other than IDLE/INHIBIT releases both lines and pulses tx_done with tx_error=1.
  - Next state is IDLE.
- When undefined: no watchdog. A silent device leaves tx_busy=1 until reset.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, RTS, DATA, STOP, ACK, WAIT_IDLE);
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4;
  - response constants RSP_ACK=8'hFA, RSP_BAT_OK=8'hAA;
  - LED bit positions SCROLL=0, NUM=1, CAPS=2.
- Sub-module ps2_line_sync: 2-FF synchroniser plus falling-edge detect for clk and data. It is shared with the receiver.

Test Plan:
- Device BFM with 40 us clock period and ACK low; send tx_data=8'hED. Require:
  - clk held low for ≥1680 cycles;
  - BFM samples bits 1,0,1,1,0,1,1,1 LSB-first, parity 1, stop 1;
  - tx_done pulses once with tx_error=0.
- Send 8'h00 → parity bit 1. Send 8'h01 → parity bit 0. Both complete with tx_error=0.
- BFM leaves data high on the ACK edge → tx_done with tx_error=1; tx_error stays 1 until the next start.
- tx_start pulsed again mid-frame, and in the tx_done cycle → ignored; exactly one frame is seen on the wire.
- Assert reset during DATA at bit4 → next cycle both oe=0 and tx_busy=0, no tx_done; a following frame with 8'h02 completes OK.
- With PS2_HOST_TX_TIMEOUT_EN, the BFM never clocks → after 210000 cycles tx_done with tx_error=1 and both lines released. Without the macro, tx_busy stays 1.
